// File: rtl/afs_abort_pkg.sv
// rtl/afs_abort_pkg.sv - shared types and constants for the abort sequencer
//
// Holds the sequencer FSM state encoding, the default timeout result
// (-EIO) and the watchdog counter width rule. The counter is sized for
// twice the timeout, so the terminal compare never wraps.

package afs_abort_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESULT,
        ST_DRAIN
    } state_t;

    localparam logic [31:0] DEFAULT_ERR_C       = 32'hFFFF_FFFB;
    localparam int          DEF_TIMEOUT_CYCLES  = 256;
    localparam int          TIMEOUT_W           = $clog2(2 * DEF_TIMEOUT_CYCLES);

    function automatic int wdog_width(input int cycles);
        return $clog2(2 * cycles);
    endfunction

endpackage

// File: rtl/afs_abort_fifo.sv
// rtl/afs_abort_fifo.sv - synchronous FIFO carrying {tag, code} entries
//
// Ports:
//   clock, reset         single clock, synchronous active-high reset
//   push, push_data      write one entry (caller guarantees !full)
//   pop                  consume the head entry (caller guarantees !empty)
//   pop_data             head entry, valid while !empty
//   full, empty          occupancy flags
//
// Storage is flop based. The head becomes visible the cycle after it is
// pushed into an empty queue. Pointers carry one extra wrap bit to tell
// full from empty.

module afs_abort_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/afs_abort_sequencer.sv
// rtl/afs_abort_sequencer.sv - queues abort codes and sequences translator calls
//
// Ports:
//   clock, reset                     single clock, synchronous active-high reset
//   in_valid/in_ready/in_abort_code/in_tag
//                                    abort codes from the RX teardown path
//   xl_start/xl_busy/xl_abort_code   translator call handshake
//   xl_done/xl_stall/xl_returndata   translator return handshake
//   out_valid/out_ready/out_error/out_tag/out_timeout
//                                    tagged errno result to call completion
//   stat_timeouts                    saturating count of watchdog fallbacks
//
// Build option: AFS_ABORT_ZERO_BYPASS_EN makes a code of 0 complete
// immediately with errno 0 and no translator call.
//
// Only one call is ever outstanding, so results leave in input order.
// After a watchdog fallback the translator may still answer; the DRAIN
// state swallows that one late return so it cannot be matched to the
// next call.

module afs_abort_sequencer
    import afs_abort_pkg::*;
#(
    parameter int          FIFO_DEPTH     = 4,
    parameter int          TAG_W          = 8,
    parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [31:0] DEFAULT_ERR    = DEFAULT_ERR_C
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_abort_code,
    input  logic [TAG_W-1:0] in_tag,
    output logic             xl_start,
    input  logic             xl_busy,
    output logic [31:0]      xl_abort_code,
    input  logic             xl_done,
    output logic             xl_stall,
    input  logic [31:0]      xl_returndata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_error,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_timeout,
    output logic [15:0]      stat_timeouts
);

    localparam int             WD_W    = wdog_width(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    state_t state;
    state_t state_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [TAG_W+31:0] fifo_head;

    logic [31:0]      code_q;
    logic [TAG_W-1:0] tag_q;
    logic [WD_W-1:0]  wd;
    logic             drain_pending;

    logic take_next;
    logic wd_clr;
    logic wd_inc;
    logic ld_done;
    logic ld_timeout;
    logic ld_zero;
    logic drain_clr;

    // Reset term keeps the queue closed while reset is held.
    assign in_ready  = !reset && !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign fifo_pop  = take_next;

    afs_abort_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (TAG_W + 32)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({in_tag, in_abort_code}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d    = state;
        take_next  = 1'b0;
        wd_clr     = 1'b0;
        wd_inc     = 1'b0;
        ld_done    = 1'b0;
        ld_timeout = 1'b0;
        ld_zero    = 1'b0;
        drain_clr  = 1'b0;

        case (state)
            ST_IDLE: begin
                take_next = !fifo_empty;
            end
            ST_ISSUE: begin
                if (!xl_busy) begin
                    state_d = ST_WAIT;
                    wd_clr  = 1'b1;
                end
            end
            ST_WAIT: begin
                // A return in the expiry cycle wins over the fallback.
                if (xl_done) begin
                    ld_done = 1'b1;
                    state_d = ST_RESULT;
                end else if (wd == WD_LAST) begin
                    ld_timeout = 1'b1;
                    state_d    = ST_RESULT;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            ST_RESULT: begin
                if (out_ready) begin
                    if (drain_pending) begin
                        state_d = ST_DRAIN;
                        wd_clr  = 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                        take_next = !fifo_empty;
                    end
                end
            end
            ST_DRAIN: begin
                if (xl_done || (wd == WD_LAST)) begin
                    state_d   = ST_IDLE;
                    drain_clr = 1'b1;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Popping from IDLE or straight out of a RESULT handshake both
        // land here, which gives back-to-back operation.
        if (take_next) begin
            state_d = ST_ISSUE;
`ifdef AFS_ABORT_ZERO_BYPASS_EN
            if (fifo_head[31:0] == 32'h0) begin
                state_d = ST_RESULT;
                ld_zero = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            code_q        <= '0;
            tag_q         <= '0;
            wd            <= '0;
            drain_pending <= 1'b0;
            out_error     <= '0;
            out_timeout   <= 1'b0;
            stat_timeouts <= '0;
        end else begin
            state <= state_d;

            if (take_next) begin
                code_q <= fifo_head[31:0];
                tag_q  <= fifo_head[TAG_W+31:32];
            end

            if (wd_clr) begin
                wd <= '0;
            end else if (wd_inc) begin
                wd <= wd + 1'b1;
            end

            if (ld_done) begin
                out_error   <= xl_returndata;
                out_timeout <= 1'b0;
            end else if (ld_timeout) begin
                out_error   <= DEFAULT_ERR;
                out_timeout <= 1'b1;
            end else if (ld_zero) begin
                out_error   <= '0;
                out_timeout <= 1'b0;
            end

            if (ld_timeout) begin
                drain_pending <= 1'b1;
                if (stat_timeouts != 16'hFFFF) begin
                    stat_timeouts <= stat_timeouts + 16'd1;
                end
            end else if (drain_clr) begin
                drain_pending <= 1'b0;
            end
        end
    end

    assign xl_start      = (state == ST_ISSUE);
    assign xl_abort_code = code_q;
    // Held in RESULT so a late return cannot land while a result is shown.
    assign xl_stall      = (state == ST_RESULT);
    assign out_valid     = (state == ST_RESULT);
    assign out_tag       = tag_q;

endmodule

// File: tb/tb_afs_abort_sequencer.sv
// tb/tb_afs_abort_sequencer.sv - directed self-checking bench for afs_abort_sequencer

module tb_afs_abort_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_abort_code = '0;
    logic [7:0]  in_tag = '0;
    logic        xl_start;
    logic        xl_busy = 1'b0;
    logic [31:0] xl_abort_code;
    logic        xl_done = 1'b0;
    logic        xl_stall;
    logic [31:0] xl_returndata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_error;
    logic [7:0]  out_tag;
    logic        out_timeout;
    logic [15:0] stat_timeouts;

    int total = 0;
    int bad   = 0;
    int calls = 0;
    bit auto_drop = 1'b0;

    afs_abort_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_abort_code (in_abort_code),
        .in_tag        (in_tag),
        .xl_start      (xl_start),
        .xl_busy       (xl_busy),
        .xl_abort_code (xl_abort_code),
        .xl_done       (xl_done),
        .xl_stall      (xl_stall),
        .xl_returndata (xl_returndata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_error     (out_error),
        .out_tag       (out_tag),
        .out_timeout   (out_timeout),
        .stat_timeouts (stat_timeouts)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!reset && xl_start && !xl_busy) calls++;
    end

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    task automatic tick();
        bit hs;
        hs = in_valid && in_ready;
        @(posedge clock);
        #1;
        if (auto_drop && hs) in_valid = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (xl_start !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("start_seen", {31'd0, xl_start}, 32'd1);
    endtask

    // Waits for the call, lets it be accepted, returns res lat cycles later.
    task automatic serve(input string nm, input logic [31:0] code, input logic [31:0] res, input int lat);
        wait_start();
        chk(nm, xl_abort_code, code);
        tick();
        repeat (lat - 1) tick();
        xl_done = 1'b1;
        xl_returndata = res;
        tick();
        xl_done = 1'b0;
    endtask

    task automatic take(input string nm, input logic [31:0] err, input logic [7:0] tag, input logic to);
        chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({nm, "_err"}, out_error, err);
        chk({nm, "_tag"}, {24'd0, out_tag}, {24'd0, tag});
        chk({nm, "_to"}, {31'd0, out_timeout}, {31'd0, to});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int c0;
        // reset
        repeat (3) tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_xl_start", {31'd0, xl_start}, 32'd0);
        chk("rst_xl_stall", {31'd0, xl_stall}, 32'd0);
        chk("rst_stat", {16'd0, stat_timeouts}, 32'd0);

        // single code: xl_start in the second cycle after the handshake
        in_valid = 1'b1; in_abort_code = 32'h66; in_tag = 8'h11;
        tick();
        in_valid = 1'b0;
        chk("t1_start_early", {31'd0, xl_start}, 32'd0);
        tick();
        chk("t1_start", {31'd0, xl_start}, 32'd1);
        chk("t1_code", xl_abort_code, 32'h66);
        tick();
        chk("t1_start_drop", {31'd0, xl_start}, 32'd0);
        tick(); tick();
        chk("t1_no_result_yet", {31'd0, out_valid}, 32'd0);
        xl_done = 1'b1; xl_returndata = 32'hFFFF_FFED;
        tick();
        xl_done = 1'b0;
        chk("t1_stall", {31'd0, xl_stall}, 32'd1);
        take("t1", 32'hFFFF_FFED, 8'h11, 1'b0);
        chk("t1_idle", {31'd0, out_valid}, 32'd0);

        // six codes back to back into a depth-4 queue
        xl_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_abort_code = 32'h100 + i; in_tag = 8'h20 + 8'(i);
            chk("t2_ready_pre", {31'd0, in_ready}, 32'd1);
            tick();
        end
        in_abort_code = 32'h105; in_tag = 8'h25;
        chk("t2_full", {31'd0, in_ready}, 32'd0);
        auto_drop = 1'b1;
        xl_busy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            serve("t2_code", 32'h100 + k, 32'hFFFF_FF00 | k, 2);
            take("t2", 32'hFFFF_FF00 | k, 8'h20 + 8'(k), 1'b0);
        end
        auto_drop = 1'b0;
        chk("t2_drained_in", {31'd0, in_valid}, 32'd0);

        // watchdog fallback, then a late return that must be discarded
        in_valid = 1'b1; in_abort_code = 32'h77; in_tag = 8'h33;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t3_start", {31'd0, xl_start}, 32'd1);
        tick();
        repeat (255) tick();
        chk("t3_not_yet", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t3_stat", {16'd0, stat_timeouts}, 32'd1);
        take("t3", 32'hFFFF_FFFB, 8'h33, 1'b1);
        repeat (10) tick();
        xl_done = 1'b1; xl_returndata = 32'h1234_5678;
        tick();
        xl_done = 1'b0;
        chk("t3_late_dropped", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1; in_abort_code = 32'h88; in_tag = 8'h44;
        tick();
        in_valid = 1'b0;
        serve("t3_next_code", 32'h88, 32'hFFFF_FFF2, 3);
        take("t3_next", 32'hFFFF_FFF2, 8'h44, 1'b0);
        chk("t3_stat_hold", {16'd0, stat_timeouts}, 32'd1);

        // translator busy for five cycles
        c0 = calls;
        xl_busy = 1'b1;
        in_valid = 1'b1; in_abort_code = 32'h99; in_tag = 8'h55;
        tick();
        in_valid = 1'b0;
        wait_start();
        for (int i = 0; i < 5; i++) begin
            chk("t4_start_hold", {31'd0, xl_start}, 32'd1);
            chk("t4_code_hold", xl_abort_code, 32'h99);
            tick();
        end
        chk("t4_start_last", {31'd0, xl_start}, 32'd1);
        xl_busy = 1'b0;
        tick();
        chk("t4_accepted", {31'd0, xl_start}, 32'd0);
        chk("t4_one_call", calls - c0, 32'd1);
        xl_done = 1'b1; xl_returndata = 32'hFFFF_FFDE;
        tick();
        xl_done = 1'b0;

        // result held with out_ready low and a spurious return
        for (int i = 0; i < 8; i++) begin
            chk("t5_valid", {31'd0, out_valid}, 32'd1);
            chk("t5_stall", {31'd0, xl_stall}, 32'd1);
            chk("t5_err", out_error, 32'hFFFF_FFDE);
            xl_done = (i == 3); xl_returndata = 32'hDEAD_BEEF;
            tick();
        end
        xl_done = 1'b0;
        take("t5", 32'hFFFF_FFDE, 8'h55, 1'b0);
        chk("t5_idle", {31'd0, out_valid}, 32'd0);

        // code zero
        c0 = calls;
        in_valid = 1'b1; in_abort_code = 32'h0; in_tag = 8'h66;
        tick();
        in_valid = 1'b0;
`ifdef AFS_ABORT_ZERO_BYPASS_EN
        tick();
        chk("t6_no_start", {31'd0, xl_start}, 32'd0);
        take("t6", 32'h0, 8'h66, 1'b0);
        chk("t6_no_call", calls - c0, 32'd0);
`else
        serve("t6_code", 32'h0, 32'hFFFF_FFEA, 2);
        take("t6", 32'hFFFF_FFEA, 8'h66, 1'b0);
        chk("t6_one_call", calls - c0, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/afs_abort_sequencer.md
Name: afs_abort_sequencer

Overview:
- Upstream and downstream wrapper around the afs_abort_to_error translator kernel.
- Queues abort codes arriving from the RX call-teardown path and issues them to the translator one at a time using its call/return handshake.
- Returns the tagged negative-errno result to the call-completion stage.
- Bounds translator latency with a watchdog.

Parameters:
- FIFO_DEPTH, 4, input queue entries; power of two, 2..16.
- TAG_W, 8, width of the call tag carried alongside each code.
- TIMEOUT_CYCLES, 256, cycles allowed from call accept to return before fallback.
- DEFAULT_ERR, 32'hFFFFFFFB, result on timeout (-EIO).

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  abort code offered
- in_ready  out  1  queue not full
- in_abort_code  in  32  raw AFS/RX abort code
- in_tag  in  TAG_W  call identifier
- xl_start  out  1  translator call.valid
- xl_busy  in  1  translator call.stall
- xl_abort_code  out  32  translator argument
- xl_done  in  1  translator return.valid
- xl_stall  out  1  translator return.stall
- xl_returndata  in  32  translator result
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_error  out  32  signed errno result
- out_tag  out  TAG_W  tag of the result
- out_timeout  out  1  result came from watchdog fallback
- stat_timeouts  out  16  saturating watchdog count

Behaviour:
- Reset: clears FIFO, FSM to IDLE, out_valid=0, xl_start=0, xl_stall=0, stat_timeouts=0.
  - in_ready=0 during reset and 1 on the first cycle after reset.
- Input transfer: in_valid && in_ready on a rising edge.
  - in_ready = !full.
  - Simultaneous push and pop while full is not allowed; in_ready stays 0 when full.
- FIFO: registered read. The head is visible one cycle after the push into an empty queue.
- FSM states: IDLE, ISSUE, WAIT, RESULT, DRAIN.
  - IDLE: if FIFO is non-empty, pop the head into the code/tag registers and go to ISSUE.
  - ISSUE: xl_start=1 and xl_abort_code=code register, held stable.
    - The call is accepted on the edge where xl_start && !xl_busy; then go to WAIT and clear the watchdog.
  - WAIT: xl_stall=0.
    - If xl_done, capture xl_returndata into out_error, set out_timeout=0, and go to RESULT.
    - Else, if the watchdog reaches TIMEOUT_CYCLES-1, load out_error=DEFAULT_ERR, set out_timeout=1, increment stat_timeouts (saturating at 16'hFFFF), and go to RESULT with drain_pending=1.
  - RESULT: out_valid=1 and outputs held stable until out_ready.
    - On handshake, go to DRAIN if drain_pending, else IDLE.
    - The IDLE pop may occur in the same cycle as the handshake, giving back-to-back operation.
    - xl_stall=1 in RESULT so a late return cannot overwrite the result.
  - DRAIN: xl_stall=0.
    - The first xl_done is discarded.
    - Exit to IDLE on that xl_done, or after a further TIMEOUT_CYCLES without one.
    - Clear drain_pending on exit.
- Latency with an empty queue, a translator with zero busy, and a return N cycles after accept:
  - input handshake to xl_start = 2 cycles;
  - xl_done to out_valid = 1 cycle.
- Only one call is outstanding at any time; results stay in input order.
- A watchdog expiry and xl_done in the same cycle: xl_done wins, with no timeout counted.
- Reset mid-call drops all state. The translator is assumed reset by the same reset.

Optional Feature:
- AFS_ABORT_ZERO_BYPASS_EN defined: in IDLE, a popped code of 32'h0 skips ISSUE/WAIT.
  - The next cycle presents out_valid with out_error=0 and out_timeout=0.
  - No translator call is made.
- Undefined: code 0 is translated like any other code.

Decomposition:
- Package afs_abort_pkg holds:
  - the FSM state enum;
  - the DEFAULT_ERR default;
  - the localparam TIMEOUT counter width, $clog2(2*TIMEOUT_CYCLES).
- One sub-module, afs_abort_fifo: a synchronous FIFO carrying {tag, code}, parameterised by depth and width, with full/empty outputs.

Test Plan:
- Single code 32'h00000066, tag 8'h11, stub returns 32'hFFFFFFED after 3 cycles -> out_error=FFFFFFED, out_tag=11, out_timeout=0; xl_start 2 cycles after input.
- 6 codes pushed back-to-back with FIFO_DEPTH=4 -> in_ready low after 4 unpopped entries; all 6 results in order with correct tags.
- Stub never returns -> out_error=FFFFFFFB, out_timeout=1, stat_timeouts=1 after TIMEOUT_CYCLES. A late xl_done 10 cycles after the fallback handshake is discarded, and the next code translates correctly.
- xl_busy held high for 5 cycles -> xl_start and xl_abort_code stable throughout; accepted on the 6th edge; exactly one call.
- out_ready held low for 8 cycles during RESULT, stub asserts a spurious xl_done -> xl_stall=1, out_error unchanged.
- With AFS_ABORT_ZERO_BYPASS_EN, code 0 -> out_error=0 with no xl_start pulse. Without the macro -> translated via the stub.
